// File: rtl/game_tick_scheduler_pkg.sv
// Shared types and default sizing for the game tick scheduler.
package game_tick_pkg;

    localparam int NUM_CH_DEF   = 4;
    localparam int PERIOD_W_DEF = 8;

    typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} chan_mode_e;
    typedef enum logic {CH_IDLE, CH_RUN} chan_state_e;

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Control/event bundle between the tick source, game logic and the scheduler.
interface game_tick_scheduler_if
    import game_tick_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int PERIOD_W = PERIOD_W_DEF
) ();
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                base_tick;
    logic                pause;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [PERIOD_W-1:0] cfg_period;
    logic                cfg_oneshot;
    logic [NUM_CH-1:0]   start;
    logic [NUM_CH-1:0]   stop;
    logic [NUM_CH-1:0]   evt_ack;
    logic [NUM_CH-1:0]   evt_pulse;
    logic [NUM_CH-1:0]   evt_pending;
    logic [NUM_CH-1:0]   evt_overrun;
    logic [NUM_CH-1:0]   active;

    modport master (
        output base_tick, pause, cfg_we, cfg_ch, cfg_period, cfg_oneshot,
        output start, stop, evt_ack,
        input  evt_pulse, evt_pending, evt_overrun, active
    );

    modport slave (
        input  base_tick, pause, cfg_we, cfg_ch, cfg_period, cfg_oneshot,
        input  start, stop, evt_ack,
        output evt_pulse, evt_pending, evt_overrun, active
    );
endinterface

// File: rtl/game_tick_scheduler_channel.sv
// One event channel: period/mode config, down-counter, IDLE/RUN FSM and
// sticky pending/overrun flags.
module game_tick_channel
    import game_tick_pkg::*;
#(
    parameter int PERIOD_W       = PERIOD_W_DEF,
    parameter int DEFAULT_PERIOD = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_tick,
    input  logic                i_cfg_we,
    input  logic [PERIOD_W-1:0] i_cfg_period,
    input  logic                i_cfg_oneshot,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_ack,
    output logic                o_pulse,
    output logic                o_pending,
    output logic                o_overrun,
    output logic                o_active
);
    chan_state_e         r_state, w_state_nxt;
    chan_mode_e          r_mode;
    logic [PERIOD_W-1:0] r_period, r_cnt, w_cnt_nxt, w_eff;
    logic                r_pulse, r_pending, r_overrun, w_fire;

    // A stored period of zero behaves as one.
    assign w_eff = (r_period == '0) ? PERIOD_W'(1) : r_period;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CH_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        if (i_stop) begin
            w_state_nxt = CH_IDLE;
        end else if (i_start) begin
            w_state_nxt = CH_RUN;
            w_cnt_nxt   = w_eff;
        end else if (r_state == CH_RUN && i_tick) begin
            if (r_cnt > PERIOD_W'(1)) begin
                w_cnt_nxt = r_cnt - PERIOD_W'(1);
            end else begin
                w_fire = 1'b1;
                if (r_mode == MODE_ONESHOT) w_state_nxt = CH_IDLE;
                else                        w_cnt_nxt   = w_eff;
            end
        end
    end

    // Config is only sampled on start/reload, so a write here never disturbs a running count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= PERIOD_W'(DEFAULT_PERIOD);
            r_mode   <= MODE_PERIODIC;
        end else if (i_cfg_we) begin
            r_period <= i_cfg_period;
            r_mode   <= i_cfg_oneshot ? MODE_ONESHOT : MODE_PERIODIC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse   <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_pulse <= w_fire;
            if (w_fire)     r_pending <= 1'b1;
            else if (i_ack) r_pending <= 1'b0;
            if (i_ack)                      r_overrun <= 1'b0;
            else if (w_fire && r_pending)   r_overrun <= 1'b1;
        end
    end

    assign o_pulse   = r_pulse;
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;
    assign o_active  = (r_state == CH_RUN);
endmodule

// File: rtl/game_tick_scheduler.sv
// Fans one base-tick stream out to NUM_CH independently programmed event channels.
module game_tick_scheduler
    import game_tick_pkg::*;
#(
    parameter int NUM_CH         = NUM_CH_DEF,
    parameter int PERIOD_W       = PERIOD_W_DEF,
    parameter int DEFAULT_PERIOD = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    game_tick_scheduler_if.slave  bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] w_cfg_we, w_pulse, w_pending, w_overrun, w_active;
    logic              w_tick;

    assign w_tick = bus.base_tick & ~bus.pause;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_cfg_we[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

        game_tick_channel #(
            .PERIOD_W       (PERIOD_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_tick        (w_tick),
            .i_cfg_we      (w_cfg_we[i]),
            .i_cfg_period  (bus.cfg_period),
            .i_cfg_oneshot (bus.cfg_oneshot),
            .i_start       (bus.start[i]),
            .i_stop        (bus.stop[i]),
            .i_ack         (bus.evt_ack[i]),
            .o_pulse       (w_pulse[i]),
            .o_pending     (w_pending[i]),
            .o_overrun     (w_overrun[i]),
            .o_active      (w_active[i])
        );
    end

    assign bus.evt_pulse   = w_pulse;
    assign bus.evt_pending = w_pending;
    assign bus.evt_overrun = w_overrun;
    assign bus.active      = w_active;
endmodule
